// File: rtl/counter_chk_pkg.sv
// rtl/counter_chk_pkg.sv - shared state encoding for the counter step checker
package counter_chk_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating incrementer with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count up on inc_i, stick at all-ones, clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/counter_step_checker.sv
// rtl/counter_step_checker.sv - checks that an observed counter steps by one in the commanded direction
module counter_step_checker
  import counter_chk_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16,
  parameter int MAX_ERR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_rst,
  input  logic             up_down,
  input  logic             valid,
  input  logic [WIDTH-1:0] out,
  input  logic             clr,
  output logic             step_ok,
  output logic             step_err,
  output logic             wrap,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail,
  output logic [1:0]       state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             dir_q, dir_d;
  logic             step_ok_q, step_ok_d;
  logic             step_err_q, step_err_d;
  logic             wrap_q, wrap_d;
  logic             fail_q;
  logic [WIDTH-1:0] expected;
  logic             accept, compare, match, err_limit;

  // A sample is taken only when nothing of higher priority claims the cycle;
  // it is compared once a previous value has been captured (PRIME or CHECK)
  always_comb begin
    accept    = valid && !clr && !cnt_rst && (state_q != ST_FAIL);
    compare   = accept && ((state_q == ST_PRIME) || (state_q == ST_CHECK));
    expected  = dir_q ? (prev_q + WIDTH'(1)) : (prev_q - WIDTH'(1));
    match     = (out == expected);
    // True when the error being recorded this cycle brings the tally to the limit
    err_limit = (({1'b0, err_cnt} + (CNT_W+1)'(1)) >= (CNT_W+1)'(MAX_ERR));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: clr beats everything, FAIL ignores cnt_rst, cnt_rst beats valid
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_FAIL) begin
      state_d = ST_FAIL;
    end else if (cnt_rst) begin
      state_d = ST_IDLE;
    end else if (valid) begin
      case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME,
        ST_CHECK: state_d = (!match && err_limit) ? ST_FAIL : ST_CHECK;
        default:  state_d = state_q;
      endcase
    end
  end

  // Output/datapath next values: pulses only on compared samples
  always_comb begin
    step_ok_d  = compare && match;
    step_err_d = compare && !match;
    wrap_d     = compare && match && (dir_q ? (prev_q == '1) : (prev_q == '0));
    prev_d     = accept ? out : prev_q;
    dir_d      = accept ? up_down : dir_q;
  end

  // Registered outputs and the previous-sample capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      dir_q      <= 1'b0;
      step_ok_q  <= 1'b0;
      step_err_q <= 1'b0;
      wrap_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      dir_q      <= dir_d;
      step_ok_q  <= step_ok_d;
      step_err_q <= step_err_d;
      wrap_q     <= wrap_d;
      fail_q     <= (state_d == ST_FAIL);
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .inc_i (step_ok_d),
    .cnt_o (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .inc_i (step_err_d),
    .cnt_o (err_cnt)
  );

  assign step_ok  = step_ok_q;
  assign step_err = step_err_q;
  assign wrap     = wrap_q;
  assign fail     = fail_q;
  assign state    = state_q;

endmodule

// File: tb/tb_counter_step_checker.sv
// tb/tb_counter_step_checker.sv - randomized self-checking bench with a behavioural reference model
module tb_counter_step_checker;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int MAXE  = 4;
  localparam int MOD   = 1 << WIDTH;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, cnt_rst, up_down, valid, clr;
  logic [WIDTH-1:0] out_s;
  logic             step_ok, step_err, wrap, fail;
  logic [CNT_W-1:0] pass_cnt, err_cnt;
  logic [1:0]       state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: spec-level view of the checker
  int m_state, m_prev, m_pass, m_err;
  bit m_dir, m_ok, m_bad, m_wrap;

  always #5 clk = ~clk;

  counter_step_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_ERR(MAXE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_rst  (cnt_rst),
    .up_down  (up_down),
    .valid    (valid),
    .out      (out_s),
    .clr      (clr),
    .step_ok  (step_ok),
    .step_err (step_err),
    .wrap     (wrap),
    .pass_cnt (pass_cnt),
    .err_cnt  (err_cnt),
    .fail     (fail),
    .state    (state)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_dir = 0; m_pass = 0; m_err = 0;
    m_ok = 0; m_bad = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit cr, input bit ud, input bit v, input int o, input bit c);
    int raw, exp;
    m_ok = 0; m_bad = 0; m_wrap = 0;
    if (c) begin
      m_pass = 0; m_err = 0; m_state = 0;
    end else if (m_state == 3) begin
      // sticky failure: nothing moves
    end else if (cr) begin
      m_state = 0;
    end else if (v) begin
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        raw = m_prev + (m_dir ? 1 : -1);
        exp = (raw + MOD) % MOD;
        if (o == exp) begin
          m_ok   = 1;
          m_wrap = (raw < 0) || (raw >= MOD);
          m_pass = (m_pass < SAT) ? m_pass + 1 : SAT;
          m_state = 2;
        end else begin
          m_bad = 1;
          m_err = (m_err < SAT) ? m_err + 1 : SAT;
          m_state = (m_err >= MAXE) ? 3 : 2;
        end
      end
      m_prev = o;
      m_dir  = ud;
    end
  endtask

  task automatic compare_all();
    check("step_ok",  int'(step_ok),  int'(m_ok));
    check("step_err", int'(step_err), int'(m_bad));
    check("wrap",     int'(wrap),     int'(m_wrap));
    check("pass_cnt", int'(pass_cnt), m_pass);
    check("err_cnt",  int'(err_cnt),  m_err);
    check("fail",     int'(fail),     (m_state == 3) ? 1 : 0);
    check("state",    int'(state),    m_state);
  endtask

  task automatic cyc(input bit cr, input bit ud, input bit v, input int o, input bit c);
    @(negedge clk);
    cnt_rst = cr; up_down = ud; valid = v; out_s = WIDTH'(o); clr = c;
    model_edge(cr, ud, v, o, c);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run_random(input int n);
    bit c, cr, v, ud;
    int o;
    for (int i = 0; i < n; i++) begin
      c  = ($urandom_range(99) < 2);
      cr = ($urandom_range(99) < 3);
      v  = ($urandom_range(99) < 85);
      ud = ($urandom_range(99) < 10) ? ~m_dir : m_dir;
      if ($urandom_range(99) < 85) o = (m_prev + (m_dir ? 1 : MOD - 1)) % MOD;
      else o = int'($urandom_range(MOD - 1));
      cyc(cr, ud, v, o, c);
    end
  endtask

  initial begin
    rst_n = 1'b0; cnt_rst = 1'b0; up_down = 1'b0; valid = 1'b0; out_s = '0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Up run 5,6,7
    cyc(0, 1, 1, 5, 0);
    cyc(0, 1, 1, 6, 0);
    check("up_first_ok", int'(step_ok), 1);
    cyc(0, 1, 1, 7, 0);
    check("up_pass2", int'(pass_cnt), 2);
    check("up_err0", int'(err_cnt), 0);
    cyc(0, 1, 0, 99, 0);

    // Wrap up then down
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 254, 0);
    cyc(0, 1, 1, 255, 0);
    check("wrap_up_not_yet", int'(wrap), 0);
    cyc(0, 1, 1, 0, 0);
    check("wrap_up", int'(wrap), 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 255, 0);
    check("wrap_down", int'(wrap), 1);
    check("wrap_down_ok", int'(step_ok), 1);

    // Errors to FAIL, then sticky, then clr with valid
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 10, 0);
    cyc(0, 1, 1, 12, 0);
    cyc(0, 1, 1, 14, 0);
    cyc(0, 1, 1, 16, 0);
    cyc(0, 1, 1, 18, 0);
    check("fail_err4", int'(err_cnt), 4);
    check("fail_set", int'(fail), 1);
    cyc(0, 1, 1, 19, 0);
    cyc(1, 1, 1, 20, 0);
    check("fail_sticky_err", int'(err_cnt), 4);
    check("fail_sticky_state", int'(state), 3);
    cyc(0, 1, 1, 21, 1);
    check("clr_fail", int'(fail), 0);
    check("clr_state", int'(state), 0);
    check("clr_nopulse", int'(step_ok | step_err), 0);

    // Mid-run cnt_rst
    cyc(0, 1, 1, 3, 0);
    cyc(0, 1, 1, 4, 0);
    cyc(1, 1, 1, 9, 0);
    check("cntrst_idle", int'(state), 0);
    cyc(0, 1, 1, 0, 0);
    check("cntrst_prime", int'(state), 1);
    check("cntrst_noerr", int'(step_err), 0);
    cyc(0, 1, 1, 1, 0);
    check("cntrst_pass2", int'(pass_cnt), 2);

    // Saturation of pass tally
    for (int i = 2; i < 22; i++) cyc(0, 1, 1, i, 0);
    check("pass_sat", int'(pass_cnt), SAT);

    // Async reset between edges while in CHECK
    @(negedge clk);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    run_random(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
